vga_sprite_compositor: RTL and testbench

- Parametrised successor to the single-frame VGA pixel path.
- Generates 640x480-class sync internally from raster counters; no divide/modulo.
- Fetches a background index-colour pixel through an external ROM port with pixel-doubling address scaling.
- Overlays NUM_SPRITES rectangular sprites with fixed priority. Sprite coordinates are double-buffered per frame (tear-free), and per-sprite collision flags are reported each frame.

---
 rtl/vga_sprite_compositor.sv | 248 ++++++++++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// vga_sprite_compositor
//   Raster generator plus pixel path for a 640x480-class VGA output. A
//   background index-colour image is fetched through an external ROM port
//   (pixel-doubled via SCALE). NUM_SPRITES solid rectangles are overlaid on
//   it with fixed priority (index 0 on top). Sprite coordinates are latched
//   once per frame, at the start of vertical blanking, so that a frame is
//   never drawn with a mix of old and new positions. Sprites that overlap on
//   a visible pixel are flagged in oCOLLIDE for the last completed frame.
//
// Ports
//   iVGA_CLK    pixel clock
//   iRST        synchronous active-high reset
//   iSPR_X/Y    packed sprite top-left corners, 10 bits per sprite
//   iSPR_EN     per-sprite enable
//   iSPR_BGR    packed sprite colours {B,G,R}, 24 bits per sprite
//   iBLACKOUT   forces every non-sprite pixel to black
//   oBG_ADDR    background ROM address
//   iBG_BGR     background ROM data, valid BG_LAT cycles after oBG_ADDR
//   oHS/oVS     active-low syncs
//   oBLANK_n    high during active video
//   b/g/r_data  colour channels
//   oFRAME_END  one-cycle strobe at the start of vertical blanking
//   oCOLLIDE    per-sprite collision flags of the last completed frame
module vga_sprite_compositor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 25,
    parameter int SPR_H       = 25,
    parameter int SCALE       = 2,
    parameter int BG_LAT      = 2,
    parameter int ADDR_W      = 19
) (
    input  logic                       iVGA_CLK,
    input  logic                       iRST,
    input  logic [NUM_SPRITES*10-1:0]  iSPR_X,
    input  logic [NUM_SPRITES*10-1:0]  iSPR_Y,
    input  logic [NUM_SPRITES-1:0]     iSPR_EN,
    input  logic [NUM_SPRITES*24-1:0]  iSPR_BGR,
    input  logic                       iBLACKOUT,
    output logic [ADDR_W-1:0]          oBG_ADDR,
    input  logic [23:0]                iBG_BGR,
    output logic                       oHS,
    output logic                       oVS,
    output logic                       oBLANK_n,
    output logic [7:0]                 b_data,
    output logic [7:0]                 g_data,
    output logic [7:0]                 r_data,
    output logic                       oFRAME_END,
    output logic [NUM_SPRITES-1:0]     oCOLLIDE
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCALE_SH = (SCALE == 4) ? 2 : ((SCALE == 2) ? 1 : 0);

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG_C = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

    localparam logic [ADDR_W-1:0] LINE_W_C = ADDR_W'(H_ACTIVE >> SCALE_SH);

    // Pipeline word: {sprite hits, hs, vs, active}
    localparam int PW = NUM_SPRITES + 3;
    localparam logic [PW-1:0] PIPE_RST = {{NUM_SPRITES{1'b0}}, 3'b110};

    // ---------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------
    logic [9:0] hCnt;
    logic [9:0] vCnt;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST_C) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST_C) ? 10'd0 : vCnt + 10'd1;
        end else begin
            hCnt <= hCnt + 10'd1;
        end
    end

    logic active;
    logic hsRaw;
    logic vsRaw;
    logic frameEnd;

    assign active   = (hCnt < H_ACT_C) && (vCnt < V_ACT_C);
    assign hsRaw    = !((hCnt >= HS_BEG_C) && (hCnt < HS_END_C));
    assign vsRaw    = !((vCnt >= VS_BEG_C) && (vCnt < VS_END_C));
    assign frameEnd = (hCnt == 10'd0) && (vCnt == V_ACT_C);

    assign oFRAME_END = frameEnd;

    // ---------------------------------------------------------------
    // Shadow sprite registers, reloaded only at the frame-end point.
    // Nothing visible is drawn between that point and the next line 0,
    // so the whole next frame sees one consistent set.
    // ---------------------------------------------------------------
    logic [9:0]  shadowX   [NUM_SPRITES];
    logic [9:0]  shadowY   [NUM_SPRITES];
    logic [23:0] shadowBgr [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] shadowEn;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            shadowEn <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadowX[i]   <= '0;
                shadowY[i]   <= '0;
                shadowBgr[i] <= '0;
            end
        end else if (frameEnd) begin
            shadowEn <= iSPR_EN;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadowX[i]   <= iSPR_X[10*i +: 10];
                shadowY[i]   <= iSPR_Y[10*i +: 10];
                shadowBgr[i] <= iSPR_BGR[24*i +: 24];
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-sprite hit test. The far edges are formed in 11 bits so a
    // sprite near coordinate 1023 is clipped instead of wrapping to 0.
    // ---------------------------------------------------------------
    logic [NUM_SPRITES-1:0] sprHit;

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : gSprite
            logic [10:0] xEnd;
            logic [10:0] yEnd;
            assign xEnd = {1'b0, shadowX[gi]} + 11'(SPR_W);
            assign yEnd = {1'b0, shadowY[gi]} + 11'(SPR_H);
            assign sprHit[gi] = shadowEn[gi]
                             && (hCnt >= shadowX[gi]) && ({1'b0, hCnt} < xEnd)
                             && (vCnt >= shadowY[gi]) && ({1'b0, vCnt} < yEnd);
        end
    endgenerate

    // ---------------------------------------------------------------
    // Collision accumulator. hit & (hit-1) clears the lowest set bit,
    // so it is non-zero exactly when two or more sprites overlap.
    // ---------------------------------------------------------------
    logic [NUM_SPRITES-1:0] collideAcc;
    logic                   multiHit;

    assign multiHit = |(sprHit & (sprHit - NUM_SPRITES'(1)));

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            collideAcc <= '0;
            oCOLLIDE   <= '0;
        end else if (frameEnd) begin
            oCOLLIDE   <= collideAcc;
            collideAcc <= '0;
        end else if (active && multiHit) begin
            collideAcc <= collideAcc | sprHit;
        end
    end

    // ---------------------------------------------------------------
    // Stage 0 address plus a BG_LAT-deep delay line that keeps the hit
    // vector and sync/blank aligned with the returning ROM data.
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] addrNext;
    logic [PW-1:0]     pipeReg [0:BG_LAT];

    assign addrNext = ADDR_W'(vCnt >> SCALE_SH) * LINE_W_C + ADDR_W'(hCnt >> SCALE_SH);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oBG_ADDR <= '0;
            for (int k = 0; k <= BG_LAT; k++) begin
                pipeReg[k] <= PIPE_RST;
            end
        end else begin
            // Address holds through blanking so the ROM sees no spurious reads.
            if (active) begin
                oBG_ADDR <= addrNext;
            end
            pipeReg[0] <= {sprHit, hsRaw, vsRaw, active};
            for (int k = 1; k <= BG_LAT; k++) begin
                pipeReg[k] <= pipeReg[k-1];
            end
        end
    end

    logic [NUM_SPRITES-1:0] alignHit;
    logic                   alignHs;
    logic                   alignVs;
    logic                   alignActive;

    assign alignHit    = pipeReg[BG_LAT][PW-1:3];
    assign alignHs     = pipeReg[BG_LAT][2];
    assign alignVs     = pipeReg[BG_LAT][1];
    assign alignActive = pipeReg[BG_LAT][0];

    // ---------------------------------------------------------------
    // Colour select: walking from the lowest priority upwards lets the
    // lowest-index hit overwrite everything else.
    // ---------------------------------------------------------------
    logic [23:0] pixSel;

    always_comb begin
        pixSel = iBLACKOUT ? 24'd0 : iBG_BGR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (alignHit[i]) begin
                pixSel = shadowBgr[i];
            end
        end
        if (!alignActive) begin
            pixSel = 24'd0;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oHS      <= 1'b1;
            oVS      <= 1'b1;
            oBLANK_n <= 1'b0;
            b_data   <= '0;
            g_data   <= '0;
            r_data   <= '0;
        end else begin
            oHS      <= alignHs;
            oVS      <= alignVs;
            oBLANK_n <= alignActive;
            b_data   <= pixSel[23:16];
            g_data   <= pixSel[15:8];
            r_data   <= pixSel[7:0];
        end
    end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb_vga_sprite_compositor
//   Drives the compositor with a reduced raster (so many frames fit in a
//   short run), a background ROM model and a per-frame sprite schedule
//   (directed frames first, then random ones). Expected outputs come from a
//   pixel-coordinate model: the pixel position is derived from the cycle
//   count since reset, sprite hits and priorities from the frame's latched
//   sprite set, and the output stream is a queue of expected pixels
//   delayed by the pipeline latency.
module tb_vga_sprite_compositor;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 48;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int NS       = 4;
    localparam int SPR_W    = 12;
    localparam int SPR_H    = 10;
    localparam int SCALE    = 2;
    localparam int BG_LAT   = 2;
    localparam int ADDR_W   = 19;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LAT      = BG_LAT + 2;
    localparam int N_FRAMES = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*10-1:0]  sprX;
    logic [NS*10-1:0]  sprY;
    logic [NS-1:0]     sprEn;
    logic [NS*24-1:0]  sprBgr;
    logic              blackout;
    logic [ADDR_W-1:0] bgAddr;
    logic [23:0]       bgBgr;
    logic              hs;
    logic              vs;
    logic              blankN;
    logic [7:0]        bData;
    logic [7:0]        gData;
    logic [7:0]        rData;
    logic              frameEnd;
    logic [NS-1:0]     collide;

    vga_sprite_compositor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .NUM_SPRITES(NS), .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE),
        .BG_LAT(BG_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .iVGA_CLK   (clk),
        .iRST       (rst),
        .iSPR_X     (sprX),
        .iSPR_Y     (sprY),
        .iSPR_EN    (sprEn),
        .iSPR_BGR   (sprBgr),
        .iBLACKOUT  (blackout),
        .oBG_ADDR   (bgAddr),
        .iBG_BGR    (bgBgr),
        .oHS        (hs),
        .oVS        (vs),
        .oBLANK_n   (blankN),
        .b_data     (bData),
        .g_data     (gData),
        .r_data     (rData),
        .oFRAME_END (frameEnd),
        .oCOLLIDE   (collide)
    );

    always #5 clk = ~clk;

    int vecCount  = 0;
    int missCount = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vecCount++;
        if (obs !== expv) begin
            missCount++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [23:0] romData(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = {13'd0, a} * 32'h9E37_79B1;
        return t[31:8];
    endfunction

    function automatic int pixAddr(input int h, input int v);
        return (v / SCALE) * (H_ACTIVE / SCALE) + h / SCALE;
    endfunction

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] bgr;
    } expPix_t;

    // Model state
    int                n;
    int                gFrame;
    logic [ADDR_W-1:0] modelAddr;
    logic [NS-1:0]     modelCollide;
    logic [NS-1:0]     modelAccum;
    int                shX   [NS];
    int                shY   [NS];
    bit                shEn  [NS];
    logic [23:0]       shBgr [NS];
    expPix_t           expQ  [$];
    logic [ADDR_W-1:0] romQ  [$];
    logic              pendingBlackout;
    bit                resetReq;
    bit                didReset;

    task automatic modelReset();
        n            = 0;
        modelAddr    = '0;
        modelCollide = '0;
        modelAccum   = '0;
        for (int i = 0; i < NS; i++) begin
            shX[i] = 0; shY[i] = 0; shEn[i] = 0; shBgr[i] = '0;
        end
        expQ.delete();
        romQ.delete();
    endtask

    task automatic setSprite(input int i, input int x, input int y, input bit en, input logic [23:0] c);
        sprX[10*i +: 10]   = 10'(x);
        sprY[10*i +: 10]   = 10'(y);
        sprEn[i]           = en;
        sprBgr[24*i +: 24] = c;
    endtask

    // Sprite set destined for frame k (latched at the end of frame k-1).
    task automatic loadConfig(input int k);
        for (int i = 0; i < NS; i++) setSprite(i, 0, 0, 1'b0, 24'h0);
        pendingBlackout = 1'b0;
        case (k)
            1: setSprite(0, 10, 5, 1'b1, 24'hFF0000);
            2: begin
                setSprite(0, 10, 5, 1'b1, 24'hFF0000);
                setSprite(1, 15, 9, 1'b1, 24'h00FF00);
            end
            3: begin
                setSprite(0, 0, 0, 1'b1, 24'hFF0000);
                setSprite(1, 40, 30, 1'b1, 24'h00FF00);
            end
            4: begin
                setSprite(2, 60, 44, 1'b1, 24'h0000FF);
                pendingBlackout = 1'b1;
            end
            default: begin
                for (int i = 0; i < NS; i++) begin
                    int x;
                    int y;
                    x = ($urandom_range(0, 7) == 0) ? 1023 - $urandom_range(0, 5)
                                                    : $urandom_range(0, H_ACTIVE + 4);
                    y = ($urandom_range(0, 7) == 0) ? 1023 - $urandom_range(0, 5)
                                                    : $urandom_range(0, V_ACTIVE + 4);
                    setSprite(i, x, y, 1'($urandom_range(0, 3) != 0), 24'($urandom));
                end
                pendingBlackout = ($urandom_range(0, 3) == 0);
            end
        endcase
    endtask

    task automatic checkReset();
        checkVal("rst_addr",      64'(bgAddr),   64'd0);
        checkVal("rst_collide",   64'(collide),  64'd0);
        checkVal("rst_frame_end", 64'(frameEnd), 64'd0);
        checkVal("rst_sync",      64'({hs, vs, blankN}), 64'b110);
        checkVal("rst_colour",    64'({bData, gData, rData}), 64'd0);
    endtask

    // One pixel clock, called just after a falling edge.
    task automatic stepCycle();
        int          h;
        int          v;
        bit          act;
        logic [NS-1:0] hits;
        expPix_t     e;

        h = n % H_TOTAL;
        v = (n / H_TOTAL) % V_TOTAL;

        // Stimulus: next frame's sprites change mid-frame, blackout in blanking
        if (h == H_ACTIVE / 2 && v == V_ACTIVE / 2) loadConfig(gFrame + 1);
        if (h == 0 && v == V_ACTIVE + 2) blackout = pendingBlackout;
        if (gFrame == 8 && v == 20 && h == 7 && !didReset) resetReq = 1'b1;

        // Background ROM with BG_LAT cycles of latency
        romQ.push_back(bgAddr);
        if (romQ.size() > BG_LAT) bgBgr = romData(romQ.pop_front());
        else                      bgBgr = '0;
        #1;

        // Expected pixel for the current raster position
        act  = (h < H_ACTIVE) && (v < V_ACTIVE);
        hits = '0;
        if (act) begin
            for (int i = 0; i < NS; i++) begin
                if (shEn[i] && h >= shX[i] && h < shX[i] + SPR_W &&
                    v >= shY[i] && v < shY[i] + SPR_H) hits[i] = 1'b1;
            end
        end
        e.hs    = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        e.vs    = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        e.blank = act;
        e.bgr   = '0;
        if (act) begin
            e.bgr = blackout ? 24'd0 : romData(ADDR_W'(pixAddr(h, v)));
            for (int i = NS - 1; i >= 0; i--) if (hits[i]) e.bgr = shBgr[i];
        end
        expQ.push_back(e);

        checkVal("frame_end", 64'(frameEnd), 64'(h == 0 && v == V_ACTIVE));
        checkVal("bg_addr",   64'(bgAddr),   64'(modelAddr));
        checkVal("collide",   64'(collide),  64'(modelCollide));
        if (expQ.size() > LAT) begin
            e = expQ.pop_front();
            checkVal("sync",   64'({hs, vs, blankN}), 64'({e.hs, e.vs, e.blank}));
            checkVal("colour", 64'({bData, gData, rData}), 64'(e.bgr));
        end else begin
            checkVal("sync_fill",   64'({hs, vs, blankN}), 64'b110);
            checkVal("colour_fill", 64'({bData, gData, rData}), 64'd0);
        end

        // Model state advance
        if (act) modelAddr = ADDR_W'(pixAddr(h, v));
        if (h == 0 && v == V_ACTIVE) begin
            $display("frame %0d end: collide=%b", gFrame, modelAccum);
            modelCollide = modelAccum;
            modelAccum   = '0;
            for (int i = 0; i < NS; i++) begin
                shX[i]   = int'(sprX[10*i +: 10]);
                shY[i]   = int'(sprY[10*i +: 10]);
                shEn[i]  = sprEn[i];
                shBgr[i] = sprBgr[24*i +: 24];
            end
            gFrame++;
        end
        if (act && $countones(hits) >= 2) modelAccum = modelAccum | hits;
        n++;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        resetReq = 1'b0;
        didReset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkReset();
        end
        rst = 1'b0;
        modelReset();
        stepCycle();
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        gFrame   = 0;
        resetReq = 1'b0;
        didReset = 1'b0;
        blackout = 1'b0;
        bgBgr    = '0;
        pendingBlackout = 1'b0;
        // Visible-looking inputs before the first latch must not show in frame 0
        for (int i = 0; i < NS; i++) setSprite(i, 8 * i, 4 * i, 1'b1, 24'h00ABCD);
        repeat (2) begin
            @(negedge clk);
            checkReset();
        end
        rst = 1'b0;
        modelReset();
        stepCycle();

        cyc = 0;
        while (gFrame < N_FRAMES && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (resetReq) doReset();
            else          stepCycle();
        end
        checkVal("frame_budget", 64'(gFrame), 64'(N_FRAMES));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
